// File: rtl/fpu_result_queue.sv
// Result FIFO between the FP add/sub unit and the register-file writeback port.
// Holds {y, ovf, tag} entries and accumulates sticky overflow / invalid flags.
module fpu_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_y,
  input  logic                     in_ovf,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     flag_of,
  output logic                     flag_nv,
  input  logic                     flag_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 33 + TAG_W;

  function automatic logic is_nan(input logic [31:0] y);
    return (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic          flag_of_q, flag_of_d;
  logic          flag_nv_q, flag_nv_d;
  logic          push;
  logic          pop;

  // Handshakes depend on occupancy only, so a pop never re-opens a full queue in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rp_q];
  assign out_data  = head[EW-1 -: 32];
  assign out_ovf   = head[TAG_W];
  assign out_tag   = head[TAG_W-1:0];
  assign count     = count_q;
  assign flag_of   = flag_of_q;
  assign flag_nv   = flag_nv_q;

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    rp_d      = rp_q;
    wp_d      = wp_q;
    count_d   = count_q;
    flag_of_d = flag_of_q;
    flag_nv_d = flag_nv_q;

    if (push) begin
      wp_d = wp_q + PW'(1);
    end else begin
      wp_d = wp_q;
    end

    if (pop) begin
      rp_d = rp_q + PW'(1);
    end else begin
      rp_d = rp_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A setting push beats a same-cycle clear.
    if (push && in_ovf) begin
      flag_of_d = 1'b1;
    end else if (flag_clr) begin
      flag_of_d = 1'b0;
    end else begin
      flag_of_d = flag_of_q;
    end

    if (push && is_nan(in_y)) begin
      flag_nv_d = 1'b1;
    end else if (flag_clr) begin
      flag_nv_d = 1'b0;
    end else begin
      flag_nv_d = flag_nv_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp_q      <= {PW{1'b0}};
      wp_q      <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      flag_of_q <= 1'b0;
      flag_nv_q <= 1'b0;
    end else begin
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      flag_of_q <= flag_of_d;
      flag_nv_q <= flag_nv_d;
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {in_y, in_ovf, in_tag};
    end
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed self-checking bench for fpu_result_queue (DEPTH=4, TAG_W=5).
module tb_fpu_result_queue;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        in_ovf;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_ovf;
  logic [2:0]  count;
  logic        flag_of;
  logic        flag_nv;
  logic        flag_clr;

  int total;
  int bad;

  fpu_result_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_ovf(in_ovf), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_ovf(out_ovf), .count(count), .flag_of(flag_of), .flag_nv(flag_nv), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_y = 32'h0; in_ovf = 1'b0; in_tag = 5'd0;
    out_ready = 1'b0; flag_clr = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if ({flag_of, flag_nv} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", flag_of, flag_nv); end
    rstn = 1'b1;
    in_y = 32'h3F800000; in_tag = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h3F800000) begin bad++; $display("FAIL first_data got=%h exp=3f800000", out_data); end
    total++; if (out_tag !== 5'd3) begin bad++; $display("FAIL first_tag got=%0d exp=3", out_tag); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_pop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill();
    for (int t = 1; t <= 5; t++) begin
      in_y = 32'h40000000 + 32'(t); in_tag = 5'(t); in_valid = 1'b1;
      total++; if (in_ready !== (t <= 4)) begin bad++; $display("FAIL fill_ready_%0d got=%b exp=%b", t, in_ready, (t <= 4)); end
      tick();
    end
    in_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid_%0d got=%b exp=1", i, out_valid); end
      total++; if (out_tag !== 5'(i)) begin bad++; $display("FAIL drain_tag_%0d got=%0d exp=%0d", i, out_tag, i); end
      total++; if (out_data !== 32'h40000000 + 32'(i)) begin bad++; $display("FAIL drain_data_%0d got=%h exp=%h", i, out_data, 32'h40000000 + 32'(i)); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    in_y = 32'h40000005; in_tag = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL repush_count got=%0d exp=1", count); end
    total++; if (out_tag !== 5'd5) begin bad++; $display("FAIL repush_tag got=%0d exp=5", out_tag); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_y = 32'hC0000000; in_tag = 5'd0; in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      in_y = 32'hC0000000 | 32'(k); in_tag = 5'(k);
      total++; if (out_tag !== 5'(k - 1)) begin bad++; $display("FAIL wrap_tag_%0d got=%0d exp=%0d", k, out_tag, k - 1); end
      total++; if (out_data !== (32'hC0000000 | 32'(k - 1))) begin bad++; $display("FAIL wrap_data_%0d got=%h exp=%h", k, out_data, 32'hC0000000 | 32'(k - 1)); end
      tick();
      total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count_%0d got=%0d exp=1", k, count); end
    end
    in_valid = 1'b0;
    total++; if (out_tag !== 5'd11) begin bad++; $display("FAIL wrap_last_tag got=%0d exp=11", out_tag); end
    tick();
    out_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_flags();
    logic [31:0] vy [3];
    logic        vovf [3];
    logic        vclr [3];
    logic        eof [3];
    logic        env [3];
    vy[0] = 32'h7F800000; vovf[0] = 1'b1; vclr[0] = 1'b0; eof[0] = 1'b1; env[0] = 1'b0;
    vy[1] = 32'hFFC00000; vovf[1] = 1'b0; vclr[1] = 1'b0; eof[1] = 1'b1; env[1] = 1'b1;
    vy[2] = 32'h7FC00001; vovf[2] = 1'b0; vclr[2] = 1'b1; eof[2] = 1'b0; env[2] = 1'b1;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_y = vy[i]; in_ovf = vovf[i]; flag_clr = vclr[i]; in_tag = 5'(20 + i); in_valid = 1'b1;
      tick();
      total++; if (flag_of !== eof[i]) begin bad++; $display("FAIL flag_of_%0d got=%b exp=%b", i, flag_of, eof[i]); end
      total++; if (flag_nv !== env[i]) begin bad++; $display("FAIL flag_nv_%0d got=%b exp=%b", i, flag_nv, env[i]); end
      total++; if (out_data !== vy[i]) begin bad++; $display("FAIL flag_data_%0d got=%h exp=%h", i, out_data, vy[i]); end
      total++; if (out_ovf !== vovf[i]) begin bad++; $display("FAIL flag_ovf_%0d got=%b exp=%b", i, out_ovf, vovf[i]); end
    end
    in_valid = 1'b0; in_ovf = 1'b0; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0; out_ready = 1'b0;
    total++; if ({flag_of, flag_nv} !== 2'b00) begin bad++; $display("FAIL flag_clear got=%b%b exp=00", flag_of, flag_nv); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flag_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_pop();
    for (int t = 8; t <= 11; t++) begin
      in_y = 32'h3F000000 + 32'(t); in_tag = 5'(t); in_valid = 1'b1;
      tick();
    end
    in_y = 32'h3F00000C; in_tag = 5'd12;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fullpop_ready got=%b exp=0", in_ready); end
    tick();
    out_ready = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    total++; if (out_tag !== 5'd9) begin bad++; $display("FAIL fullpop_head got=%0d exp=9", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_reopen got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_refill got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int t = 9; t <= 12; t++) begin
      total++; if (out_tag !== 5'(t)) begin bad++; $display("FAIL fullpop_order_%0d got=%0d exp=%0d", t, out_tag, t); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fullpop_end got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    in_y = 32'h7FC00000; in_ovf = 1'b1; in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_tag = 5'(t);
      tick();
    end
    in_valid = 1'b0; in_ovf = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    total++; if ({flag_of, flag_nv} !== 2'b11) begin bad++; $display("FAIL mid_pre_flags got=%b%b exp=11", flag_of, flag_nv); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if ({flag_of, flag_nv} !== 2'b00) begin bad++; $display("FAIL mid_flags got=%b%b exp=00", flag_of, flag_nv); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    #1;
    rstn = 1'b1;
    in_y = 32'h80000000; in_tag = 5'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h80000000) begin bad++; $display("FAIL post_data got=%h exp=80000000", out_data); end
    total++; if (out_tag !== 5'd7) begin bad++; $display("FAIL post_tag got=%0d exp=7", out_tag); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL post_count got=%0d exp=1", count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_flags();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_result_queue.md
# fpu_result_queue

Result buffer directly downstream of the single-precision add/subtract unit. It captures each unit result (32-bit IEEE-754 word plus overflow flag) with its destination register tag into a small FIFO, and drains it to the FP register-file writeback port through a valid/ready handshake. It also accumulates sticky exception flags (overflow, invalid/NaN) for the FP status register. This decouples the combinational arithmetic unit from writeback-port stalls.

## Interface

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- TAG_W, 5, width of the destination register tag

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  queue can accept; = (count != DEPTH)
- in_y  in  32  result word {sign, exp[7:0], mant[22:0]}
- in_ovf  in  1  overflow flag from the arithmetic unit
- in_tag  in  TAG_W  destination register index
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  writeback accepts head
- out_data  out  32  head entry result word
- out_tag  out  TAG_W  head entry tag
- out_ovf  out  1  head entry overflow flag
- count  out  $clog2(DEPTH)+1  current occupancy
- flag_of  out  1  sticky overflow
- flag_nv  out  1  sticky invalid (NaN result accepted)
- flag_clr  in  1  synchronous clear of both sticky flags

## Operation

- Storage: DEPTH entries of {y[31:0], ovf, tag}. Read pointer rp, write pointer wp, each $clog2(DEPTH) bits; both wrap modulo DEPTH with no special case.
- Push = in_valid & in_ready: write entry at wp, wp += 1.
- Pop = out_valid & out_ready: rp += 1.
- count: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- Full (count == DEPTH): in_ready = 0, and a same-cycle pop does not re-open in_ready (no pass-through). in_valid is ignored.
- Empty (count == 0): out_valid = 0, and out_ready is ignored. A pushed entry is not visible until the next cycle (no bypass).
- out_data/out_tag/out_ovf are the storage contents at rp. When out_valid = 0 their value is don't-care; the bench must not check them.
- Data is passed through unmodified. NaN payloads, signed zeros and infinities are stored bit-exact.
- NaN detect on in_y: exp == 8'hFF and mant != 0.
- Sticky flags update only on a push:
  - flag_of sets if in_ovf = 1.
  - flag_nv sets if in_y is a NaN.
  - Infinity (mant == 0) does not set flag_nv.
- flag_clr = 1 clears both flags at the next edge. If a setting push occurs in the same cycle, the set wins (flag = 1 after the edge).
- Upstream contract: in_y/in_ovf/in_tag are held stable while in_valid = 1 and in_ready = 0. The queue does not check this.

## Timing

- Reset (rstn low, asynchronous):
  - rp = wp = count = 0, flag_of = flag_nv = 0.
  - Hence out_valid = 0 and in_ready = 1 while in reset.
  - Storage is not reset.
- Reset asserted mid-operation discards all entries immediately. The first edge after rstn deasserts may accept a push.
- Latency: a push at edge N gives out_valid = 1 after edge N (visible in cycle N+1) if the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready and out_valid are combinational from count only. There is no combinational path from in_valid to out_valid or from out_ready to in_ready.
- Flags reflect a push or clear one cycle after the edge, i.e. registered.

## Test plan

- Reset then idle: out_valid=0, in_ready=1, count=0, flags 0. Push {y=32'h3F800000, tag=3} → next cycle out_valid=1, out_data=32'h3F800000, out_tag=3, count=1.
- Fill with out_ready=0 (DEPTH=4), pushing tags 1..5 on consecutive cycles → count=4, in_ready=0, tag 5 not accepted. Then raise out_ready → tags pop in order 1,2,3,4. Re-push of tag 5 succeeds.
- Wrap-around: run 11 push/pop pairs with count held at 1–2 → order preserved; rp/wp wrap at 4 with no loss.
- Flags:
  - Push 32'h7F800000 with in_ovf=1 → flag_of=1, flag_nv=0.
  - Push 32'hFFC00000 → flag_nv=1.
  - Assert flag_clr together with a NaN push → flag_nv stays 1, flag_of clears.
- Full with simultaneous pop: count=4, out_ready=1, in_valid=1 → this cycle pops only, count=3. The push is accepted next cycle.
- Assert rstn low with count=3 mid-stream → out_valid drops without waiting for a clock edge, flags=0. After release, a push of 32'h80000000 emerges bit-exact.
